// File: rtl/elevator_scheduler_if.sv
// Control and status bundle between the elevator car controller and its environment
// (call buttons, timebase, display and status consumers).
interface elevator_scheduler_if;
    logic       powerOn;
    logic       tick;
    logic [7:0] req;
    logic [2:0] floor;
    logic [3:0] remainTime;
    logic       door_open;
    logic       dir;
    logic       moving;
    logic [7:0] pending;

    modport master (
        output powerOn, tick, req,
        input  floor, remainTime, door_open, dir, moving, pending
    );

    modport slave (
        input  powerOn, tick, req,
        output floor, remainTime, door_open, dir, moving, pending
    );
endinterface

// File: rtl/elevator_scheduler.sv
// Elevator car controller: latches floor calls, schedules travel with SCAN,
// and times floor-to-floor moves and door dwell on the tick strobe.
module elevator_scheduler #(
    parameter int NUM_FLOORS = 8,
    parameter int MOVE_TIME  = 3,
    parameter int DOOR_TIME  = 5
) (
    input logic            clk,
    input logic            rst,
    elevator_scheduler_if.slave bus
);

    localparam logic [7:0] FLOOR_MASK = 8'((9'd1 << NUM_FLOORS) - 9'd1);
    localparam logic [2:0] TOP_FLOOR  = 3'(NUM_FLOORS - 1);
    localparam logic [3:0] MOVE_LOAD  = 4'(MOVE_TIME);
    localparam logic [3:0] DOOR_LOAD  = 4'(DOOR_TIME);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_e;

    state_e     state_q;
    logic [2:0] floor_q;
    logic [3:0] remain_q;
    logic       dir_q;
    logic [7:0] pending_q;

    logic [7:0] reqMasked;
    logic [7:0] pending_d;
    logic [2:0] floorUp;
    logic [2:0] floorDown;
    logic [3:0] remainDec;
    logic       hereNow;
    logic       aboveNow;
    logic       belowNow;

    function automatic logic callsAbove(input logic [7:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic callsBelow(input logic [7:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] clearFloor(input logic [7:0] p, input logic [2:0] f);
        return p & ~(8'd1 << f);
    endfunction

    // pending_d already includes this cycle's calls, so decisions see a call pressed "now"
    always_comb begin
        reqMasked = bus.req & FLOOR_MASK;
        pending_d = pending_q | reqMasked;
        floorUp   = (floor_q == TOP_FLOOR) ? floor_q : floor_q + 3'd1;
        floorDown = (floor_q == 3'd0) ? floor_q : floor_q - 3'd1;
        remainDec = (remain_q == 4'd0) ? 4'd0 : remain_q - 4'd1;
        hereNow   = pending_d[floor_q];
        aboveNow  = callsAbove(pending_d, floor_q);
        belowNow  = callsBelow(pending_d, floor_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            floor_q   <= 3'd0;
            remain_q  <= 4'd0;
            dir_q     <= 1'b1;
            pending_q <= 8'd0;
        end else if (!bus.powerOn) begin
            state_q   <= IDLE;
            remain_q  <= 4'd0;
            pending_q <= 8'd0;
        end else begin
            pending_q <= pending_d;
            unique case (state_q)
                IDLE: begin
                    if (hereNow) begin
                        state_q   <= DOOR;
                        remain_q  <= DOOR_LOAD;
                        pending_q <= clearFloor(pending_d, floor_q);
                    end else if (aboveNow && (dir_q || !belowNow)) begin
                        state_q  <= UP;
                        dir_q    <= 1'b1;
                        remain_q <= MOVE_LOAD;
                    end else if (belowNow) begin
                        state_q  <= DOWN;
                        dir_q    <= 1'b0;
                        remain_q <= MOVE_LOAD;
                    end
                end
                UP: begin
                    if (bus.tick) begin
                        if (remain_q == 4'd1) begin
                            floor_q <= floorUp;
                            if (pending_d[floorUp]) begin
                                state_q   <= DOOR;
                                remain_q  <= DOOR_LOAD;
                                pending_q <= clearFloor(pending_d, floorUp);
                            end else if (callsAbove(pending_d, floorUp)) begin
                                remain_q <= MOVE_LOAD;
                            end else begin
                                state_q  <= IDLE;
                                remain_q <= 4'd0;
                            end
                        end else begin
                            remain_q <= remainDec;
                        end
                    end
                end
                DOWN: begin
                    if (bus.tick) begin
                        if (remain_q == 4'd1) begin
                            floor_q <= floorDown;
                            if (pending_d[floorDown]) begin
                                state_q   <= DOOR;
                                remain_q  <= DOOR_LOAD;
                                pending_q <= clearFloor(pending_d, floorDown);
                            end else if (callsBelow(pending_d, floorDown)) begin
                                remain_q <= MOVE_LOAD;
                            end else begin
                                state_q  <= IDLE;
                                remain_q <= 4'd0;
                            end
                        end else begin
                            remain_q <= remainDec;
                        end
                    end
                end
                DOOR: begin
                    // A call for the open floor extends the dwell instead of being latched
                    pending_q <= clearFloor(pending_d, floor_q);
                    if (reqMasked[floor_q]) begin
                        remain_q <= DOOR_LOAD;
                    end else if (bus.tick) begin
                        if (remain_q == 4'd1) begin
                            state_q  <= IDLE;
                            remain_q <= 4'd0;
                        end else begin
                            remain_q <= remainDec;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.floor      = floor_q;
    assign bus.remainTime = remain_q;
    assign bus.door_open  = (state_q == DOOR);
    assign bus.dir        = dir_q;
    assign bus.moving     = (state_q == UP) || (state_q == DOWN);
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomized scoreboard bench for elevator_scheduler, checked against a
// behavioural model of the SCAN car built from the call/timing rules.
module tb_elevator_scheduler;

    localparam int NF = 8;
    localparam int MT = 3;
    localparam int DT = 5;

    logic       clk;
    logic       rst;
    logic       powerOn;
    logic       tick;
    logic [7:0] req;

    elevator_scheduler_if busMain ();
    elevator_scheduler_if busSmall ();

    assign busMain.powerOn  = powerOn;
    assign busMain.tick     = tick;
    assign busMain.req      = req;
    assign busSmall.powerOn = powerOn;
    assign busSmall.tick    = tick;
    assign busSmall.req     = req;

    elevator_scheduler #(.NUM_FLOORS(NF), .MOVE_TIME(MT), .DOOR_TIME(DT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busMain.slave)
    );

    elevator_scheduler #(.NUM_FLOORS(4), .MOVE_TIME(MT), .DOOR_TIME(DT)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (busSmall.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int floor;
        int remain;
        int door;
        int dir;
        int moving;
        int pending;
    } exp_t;

    typedef enum {mIdle, mUp, mDown, mDoor} mphase_e;

    exp_t    expQ[$];
    int      checks = 0;
    int      errors = 0;
    bit      monitorOn = 1'b0;

    mphase_e mState;
    int      mFloor;
    int      mDir;
    int      mRemain;
    bit      mPend[NF];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pendVector();
        int v = 0;
        for (int i = 0; i < NF; i++) if (mPend[i]) v += (1 << i);
        return v;
    endfunction

    function automatic bit callsAhead(input int f, input bit up);
        for (int i = 0; i < NF; i++) begin
            if (mPend[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        mState  = mIdle;
        mFloor  = 0;
        mDir    = 1;
        mRemain = 0;
        for (int i = 0; i < NF; i++) mPend[i] = 1'b0;
    endtask

    // One clock of car behaviour, given the inputs present at that clock edge
    task automatic modelStep(input bit pw, input bit tk, input logic [7:0] rq);
        bit callNow[NF];
        for (int i = 0; i < NF; i++) callNow[i] = rq[i];
        if (!pw) begin
            mState  = mIdle;
            mRemain = 0;
            for (int i = 0; i < NF; i++) mPend[i] = 1'b0;
            return;
        end
        for (int i = 0; i < NF; i++) mPend[i] = mPend[i] | callNow[i];
        case (mState)
            mIdle: begin
                if (mPend[mFloor]) begin
                    mState = mDoor;
                    mRemain = DT;
                    mPend[mFloor] = 1'b0;
                end else if (callsAhead(mFloor, 1'b1) && (mDir == 1 || !callsAhead(mFloor, 1'b0))) begin
                    mState = mUp;
                    mDir = 1;
                    mRemain = MT;
                end else if (callsAhead(mFloor, 1'b0)) begin
                    mState = mDown;
                    mDir = 0;
                    mRemain = MT;
                end
            end
            mUp, mDown: begin
                if (tk) begin
                    if (mRemain == 1) begin
                        mFloor += (mState == mUp) ? 1 : -1;
                        if (mPend[mFloor]) begin
                            mState = mDoor;
                            mRemain = DT;
                            mPend[mFloor] = 1'b0;
                        end else if (callsAhead(mFloor, mState == mUp)) begin
                            mRemain = MT;
                        end else begin
                            mState = mIdle;
                            mRemain = 0;
                        end
                    end else if (mRemain > 0) begin
                        mRemain--;
                    end
                end
            end
            mDoor: begin
                mPend[mFloor] = 1'b0;
                if (callNow[mFloor]) begin
                    mRemain = DT;
                end else if (tk) begin
                    if (mRemain == 1) begin
                        mState = mIdle;
                        mRemain = 0;
                    end else if (mRemain > 0) begin
                        mRemain--;
                    end
                end
            end
            default: mState = mIdle;
        endcase
    endtask

    task automatic applyStimulus(input bit pw, input bit tk, input logic [7:0] rq);
        exp_t e;
        @(negedge clk);
        powerOn = pw;
        tick    = tk;
        req     = rq;
        modelStep(pw, tk, rq);
        e.floor   = mFloor;
        e.remain  = mRemain;
        e.door    = (mState == mDoor) ? 1 : 0;
        e.dir     = mDir;
        e.moving  = (mState == mUp || mState == mDown) ? 1 : 0;
        e.pending = pendVector();
        expQ.push_back(e);
        monitorOn = 1'b1;
    endtask

    task automatic runTicks(input int cycles, input int period, input logic [7:0] firstReq);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(1'b1, (c % period) == (period - 1), (c == 0) ? firstReq : 8'h00);
        end
    endtask

    // Monitor: compares DUT status against the oldest queued expectation after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (monitorOn) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboardEmpty", 0, 1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("floor",      int'(busMain.floor),      e.floor);
                    checkOutput("remainTime", int'(busMain.remainTime), e.remain);
                    checkOutput("door_open",  int'(busMain.door_open),  e.door);
                    checkOutput("dir",        int'(busMain.dir),        e.dir);
                    checkOutput("moving",     int'(busMain.moving),     e.moving);
                    checkOutput("pending",    int'(busMain.pending),    e.pending);
                end
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b0;
        powerOn = 1'b0;
        tick = 1'b0;
        req = 8'h00;
        #3 rst = 1'b1;
        #1;
        checkOutput("resetFloor",   int'(busMain.floor),      0);
        checkOutput("resetRemain",  int'(busMain.remainTime), 0);
        checkOutput("resetDoor",    int'(busMain.door_open),  0);
        checkOutput("resetDir",     int'(busMain.dir),        1);
        checkOutput("resetMoving",  int'(busMain.moving),     0);
        checkOutput("resetPending", int'(busMain.pending),    0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        runTicks(12, 2, 8'h01);
        runTicks(40, 2, 8'h08);
        runTicks(100, 2, 8'h22);

        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            applyStimulus(1'b1, (c % 2) == 1, (c == 0) ? 8'h04 : 8'h00);
            found = (mState == mDoor && mFloor == 2 && mRemain == 2);
        end
        checkOutput("reachDoorFloor2", int'(found), 1);
        applyStimulus(1'b1, 1'b0, 8'h04);
        runTicks(30, 2, 8'h00);

        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            applyStimulus(1'b1, (c % 2) == 1, (c == 0) ? 8'h20 : 8'h00);
            found = (mState == mUp && mRemain == 2);
        end
        checkOutput("reachMidMove", int'(found), 1);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, (c % 2) == 0, 8'hFF);
        runTicks(20, 2, 8'h00);

        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0,
                          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
        end

        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            applyStimulus(1'b1, (c % 2) == 1, (c == 0) ? 8'h40 : 8'h00);
            found = (mState == mDoor && mFloor == 6);
        end
        checkOutput("reachDoorFloor6", int'(found), 1);
        @(posedge clk);
        #2;
        monitorOn = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstFloor",   int'(busMain.floor),      0);
        checkOutput("asyncRstRemain",  int'(busMain.remainTime), 0);
        checkOutput("asyncRstDoor",    int'(busMain.door_open),  0);
        checkOutput("asyncRstDir",     int'(busMain.dir),        1);
        checkOutput("asyncRstPending", int'(busMain.pending),    0);

        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b1, 1'b0, 8'hF0);
        @(posedge clk);
        #2;
        monitorOn = 1'b0;
        checkOutput("smallPendingMasked", int'(busSmall.pending), 0);
        checkOutput("smallMoving",        int'(busSmall.moving),  0);
        checkOutput("smallFloor",         int'(busSmall.floor),   0);
        checkOutput("scoreboardDrained",  expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
